// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, FSM state and operand field types for the FP multiplier
package fp_pkg;
  localparam int FP_BIAS = 127;
  localparam int FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam int FP_MAN_W = 24;
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_NORM, S_DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [7:0] exp;
    logic [FP_MAN_W-1:0] mant;
  } fp_fields_t;
endpackage

// File: rtl/fp_mant_mul_seq.sv
// fp_mant_mul_seq: radix-2 shift-add mantissa multiplier, one multiplier bit per step
module fp_mant_mul_seq #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplr_i,
  input  logic           step_i,
  output logic           last_o,
  output logic [2*W-1:0] prod_o
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] mcand_q, acc_q;
  logic [W-1:0] mplr_q;
  logic [CW-1:0] cnt_q;
  // load clears the accumulator; each step adds the shifted multiplicand when the multiplier LSB is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      mplr_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      mcand_q <= {{W{1'b0}}, mcand_i};
      mplr_q <= mplr_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= mplr_q[0] ? acc_q + mcand_q : acc_q;
      mcand_q <= mcand_q << 1;
      mplr_q <= mplr_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign last_o = cnt_q == CW'(W - 1);
  assign prod_o = acc_q;
endmodule

// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential single-precision multiplier with start/done handshake
module fp_mult_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = FP_MAN_W,
  parameter int BIAS = FP_BIAS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   signoA,
  input  logic [EXP_W-1:0]       exponenteA,
  input  logic [MAN_W-1:0]       mantissaA,
  input  logic                   signoB,
  input  logic [EXP_W-1:0]       exponenteB,
  input  logic [MAN_W-1:0]       mantissaB,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int RW = EXP_W + MAN_W;
  localparam logic signed [EXP_W+1:0] E_BIAS = (EXP_W + 2)'(BIAS);
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W + 2)'(FP_EXP_MAX);
  localparam logic signed [EXP_W+1:0] E_ZERO = '0;
  state_t state_q, state_d;
  fp_fields_t op_a, op_b;
  logic sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d;
  logic signed [EXP_W+1:0] exp_q, exp_d, e_n;
  logic [RW-1:0] res_q, res_d, spec_res;
  logic [MAN_W-2:0] frac;
  logic [2*MAN_W-1:0] prod;
  logic load, step, last;
  logic a_max, b_max, a_zero, b_zero, is_nan, is_inf, is_zero;
  assign op_a = '{signoA, exponenteA, mantissaA};
  assign op_b = '{signoB, exponenteB, mantissaB};
  assign a_max = &op_a.exp;
  assign b_max = &op_b.exp;
  assign a_zero = ~|op_a.exp;
  assign b_zero = ~|op_b.exp;
  assign is_nan = (a_max && |op_a.mant[MAN_W-2:0]) || (b_max && |op_b.mant[MAN_W-2:0]) || (a_max && b_zero) || (b_max && a_zero);
  assign is_inf = a_max || b_max;
  assign is_zero = a_zero || b_zero;
  assign spec_res = is_nan ? FP_QNAN : is_inf ? {op_a.sign ^ op_b.sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}} : {op_a.sign ^ op_b.sign, {(RW-1){1'b0}}};
  assign e_n = exp_q + $signed({{(EXP_W+1){1'b0}}, prod[2*MAN_W-1]});
  assign frac = prod[2*MAN_W-1] ? prod[2*MAN_W-2:MAN_W] : prod[2*MAN_W-3:MAN_W-1];
  fp_mant_mul_seq #(.W(MAN_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .mcand_i(op_a.mant),
    .mplr_i(op_b.mant),
    .step_i(step),
    .last_o(last),
    .prod_o(prod)
  );
  // state and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q <= 1'b0;
      exp_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // next state: accept operands in IDLE, short-circuit special values, normalise and pack after the loop
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    exp_d = exp_q;
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    load = 1'b0;
    step = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        load = 1'b1;
        sign_d = op_a.sign ^ op_b.sign;
        exp_d = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - E_BIAS;
        if (is_nan || is_inf || is_zero) begin
          res_d = spec_res;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          state_d = S_DONE;
        end else state_d = S_MULT;
      end
      S_MULT: begin
        step = 1'b1;
        state_d = last ? S_NORM : S_MULT;
      end
      S_NORM: begin
        ovf_d = e_n >= E_MAX;
        unf_d = !ovf_d && e_n <= E_ZERO;
        res_d = ovf_d ? {sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}} : unf_d ? {sign_q, {(RW-1){1'b0}}} : {sign_q, e_n[EXP_W-1:0], frac};
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign busy = state_q == S_MULT || state_q == S_NORM;
  assign done = state_q == S_DONE;
  assign result = res_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: scoreboard-driven bench for the sequential FP multiplier
module tb_fp_mult_seq;
  logic clk = 0, rst = 1, start = 0;
  logic signoA = 0, signoB = 0;
  logic [7:0] exponenteA = 0, exponenteB = 0;
  logic [23:0] mantissaA = 0, mantissaB = 0;
  logic busy, done, overflow, underflow;
  logic [31:0] result;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic [31:0] res;
    logic ovf;
    logic unf;
    int lat;
  } exp_t;
  exp_t sb[$];

  fp_mult_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .signoA(signoA), .exponenteA(exponenteA), .mantissaA(mantissaA),
    .signoB(signoB), .exponenteB(exponenteB), .mantissaB(mantissaB),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    signoA = a[31];
    exponenteA = a[30:23];
    mantissaA = {|a[30:23], a[22:0]};
    signoB = b[31];
    exponenteB = b[30:23];
    mantissaB = {|b[30:23], b[22:0]};
  endtask

  task automatic check_pop(input string name, input int lat, input int nbusy);
    exp_t e;
    e = sb.pop_front();
    n_checks += 5;
    if (result !== e.res) begin n_fail++; $display("FAIL %s result: got %h expected %h", name, result, e.res); end
    if (overflow !== e.ovf) begin n_fail++; $display("FAIL %s overflow: got %b expected %b", name, overflow, e.ovf); end
    if (underflow !== e.unf) begin n_fail++; $display("FAIL %s underflow: got %b expected %b", name, underflow, e.unf); end
    if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat); end
    if (nbusy !== e.lat - 1) begin n_fail++; $display("FAIL %s busy cycles: got %0d expected %0d", name, nbusy, e.lat - 1); end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf, input logic unf, input int lat);
    int lat_obs = 0, nbusy = 0;
    @(negedge clk);
    drive(a, b);
    start = 1;
    sb.push_back('{res, ovf, unf, lat});
    for (int k = 1; k <= 40 && lat_obs == 0; k++) begin
      @(negedge clk);
      start = 0;
      if (done) lat_obs = k;
      else if (busy) nbusy++;
    end
    if (lat_obs == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      void'(sb.pop_front());
    end else check_pop(name, lat_obs, nbusy);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL %s: got %0d busy/done cycles expected 0", name, seen); end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({busy, done, result, overflow, underflow} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h ovf=%b unf=%b expected all 0", busy, done, result, overflow, underflow);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_normal;
    run_op("1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 26);
    run_op("1.5x1.5", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 26);
    run_op("neg2xneg2", 32'hC0000000, 32'hC0000000, 32'h40800000, 0, 0, 26);
    run_op("3x5", 32'h40400000, 32'h40A00000, 32'h41700000, 0, 0, 26);
    run_op("trunc", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 0, 0, 26);
    run_op("negx", 32'hBFC00000, 32'h40000000, 32'hC0400000, 0, 0, 26);
  endtask

  task automatic test_range;
    run_op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0, 26);
    run_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 26);
  endtask

  task automatic test_special;
    run_op("zero", 32'h00000000, 32'h40400000, 32'h00000000, 0, 0, 1);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1);
    run_op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 1);
    run_op("nan_in", 32'h3F800000, 32'h7F800001, 32'h7FC00000, 0, 0, 1);
  endtask

  task automatic test_ignored_start;
    int lat_obs = 0, nbusy = 0;
    @(negedge clk);
    drive(32'h3FC00000, 32'h40000000);
    start = 1;
    sb.push_back('{32'h40400000, 1'b0, 1'b0, 26});
    for (int k = 1; k <= 40 && lat_obs == 0; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) drive(32'h40400000, 32'h40A00000);
      if (done) lat_obs = k;
      else if (busy) nbusy++;
    end
    if (lat_obs == 0) begin
      n_checks++; n_fail++;
      $display("FAIL ignored_start timeout: no done within 40 cycles");
      void'(sb.pop_front());
    end else check_pop("ignored_start", lat_obs, nbusy);
    drive(32'hC0000000, 32'hC0000000);
    start = 1;
    @(negedge clk);
    start = 0;
    expect_quiet("start_in_done", 30);
    n_checks++;
    if (result !== 32'h40400000) begin n_fail++; $display("FAIL ignored_start held result: got %h expected %h", result, 32'h40400000); end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    drive(32'h40400000, 32'h40A00000);
    start = 1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 0;
    end
    rst = 1;
    #1;
    n_checks++;
    if ({busy, done, result, overflow, underflow} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_abort outputs: got busy=%b done=%b result=%h ovf=%b unf=%b expected all 0", busy, done, result, overflow, underflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    expect_quiet("reset_abort no done", 30);
    run_op("after_reset", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 26);
  endtask

  initial begin
    test_reset;
    test_normal;
    test_range;
    test_special;
    test_ignored_start;
    test_reset_abort;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
